// File: rtl/load_queue_mp.sv
// Multi-port load queue: in-order dispatch, out-of-order address writes,
// oldest-first issue to the D-cache and in-order multi-entry retirement.
module load_queue_mp #(
    parameter int LDQ_ENTRIES  = 16,
    parameter int SDQ_ENTRIES  = 16,
    parameter int DISP_WIDTH   = 2,
    parameter int EXEC_PORTS   = 2,
    parameter int RETIRE_WIDTH = 2,
    parameter int ORDER_MODE   = 1,
    localparam int IW  = $clog2(LDQ_ENTRIES),
    localparam int SMW = $clog2(SDQ_ENTRIES) + 1,
    localparam int RCW = $clog2(RETIRE_WIDTH + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic [DISP_WIDTH-1:0]      disp_vld_i,
    input  logic [DISP_WIDTH*SMW-1:0]  disp_sdq_marker_i,
    output logic [DISP_WIDTH*IW-1:0]   disp_idx_o,
    output logic                       ldq_full_o,
    input  logic [EXEC_PORTS-1:0]      exec_vld_i,
    input  logic [EXEC_PORTS*IW-1:0]   exec_idx_i,
    input  logic [EXEC_PORTS*32-1:0]   exec_addr_i,
    input  logic [SMW-1:0]             sdq_head_i,
    output logic                       issue_vld_o,
    input  logic                       issue_rdy_i,
    output logic [IW-1:0]              issue_idx_o,
    output logic [31:0]                issue_addr_o,
    input  logic                       resp_vld_i,
    input  logic [IW-1:0]              resp_idx_i,
    output logic [RCW-1:0]             retire_cnt_o
);

    localparam int PW      = IW + 1;
    localparam int RET_MAX = (RETIRE_WIDTH < LDQ_ENTRIES) ? RETIRE_WIDTH : LDQ_ENTRIES;
    localparam logic [PW-1:0] FULL_THRESH = PW'(LDQ_ENTRIES - DISP_WIDTH);

    logic [LDQ_ENTRIES-1:0] valid_q, valid_d;
    logic [LDQ_ENTRIES-1:0] addr_vld_q, addr_vld_d;
    logic [LDQ_ENTRIES-1:0] issued_q, issued_d;
    logic [LDQ_ENTRIES-1:0] done_q, done_d;
    logic [31:0]            addr_q   [LDQ_ENTRIES];
    logic [31:0]            addr_d   [LDQ_ENTRIES];
    logic [SMW-1:0]         marker_q [LDQ_ENTRIES];
    logic [SMW-1:0]         marker_d [LDQ_ENTRIES];
    logic [PW-1:0]          head_q, head_d;
    logic [PW-1:0]          tail_q, tail_d;

    logic [PW-1:0]          count;
    logic [PW-1:0]          disp_cnt;
    logic [IW-1:0]          disp_slot_idx [DISP_WIDTH];
    logic [SMW-1:0]         disp_marker   [DISP_WIDTH];
    logic [IW-1:0]          ex_idx        [EXEC_PORTS];
    logic [31:0]            ex_addr       [EXEC_PORTS];
    logic [LDQ_ENTRIES-1:0] eligible;
    logic                   issue_found;
    logic [IW-1:0]          issue_sel;
    logic [RCW-1:0]         retire_cnt;

    assign count      = tail_q - head_q;
    assign ldq_full_o = (count > FULL_THRESH);

    for (genvar k = 0; k < DISP_WIDTH; k++) begin : g_disp
        assign disp_slot_idx[k]          = tail_q[IW-1:0] + IW'(k);
        assign disp_marker[k]            = disp_sdq_marker_i[k*SMW +: SMW];
        assign disp_idx_o[k*IW +: IW]    = disp_slot_idx[k];
    end

    for (genvar p = 0; p < EXEC_PORTS; p++) begin : g_exec
        assign ex_idx[p]  = exec_idx_i[p*IW +: IW];
        assign ex_addr[p] = exec_addr_i[p*32 +: 32];
    end

    // A load waits for its address and, when ordering is enabled, for every
    // store older than it to have left the SDQ (head caught up with marker).
    for (genvar i = 0; i < LDQ_ENTRIES; i++) begin : g_elig
        assign eligible[i] = valid_q[i] & addr_vld_q[i] & ~issued_q[i] &
                             ((ORDER_MODE == 0) || (sdq_head_i == marker_q[i]));
    end

    always_comb begin
        disp_cnt = '0;
        for (int k = 0; k < DISP_WIDTH; k++) begin
            disp_cnt = disp_cnt + PW'(disp_vld_i[k]);
        end
    end

    // Scan from head so that the first hit is the oldest eligible load.
    always_comb begin
        issue_found = 1'b0;
        issue_sel   = '0;
        for (int a = 0; a < LDQ_ENTRIES; a++) begin
            if (!issue_found && eligible[head_q[IW-1:0] + IW'(a)]) begin
                issue_found = 1'b1;
                issue_sel   = head_q[IW-1:0] + IW'(a);
            end
        end
    end

    assign issue_vld_o  = issue_found;
    assign issue_idx_o  = issue_sel;
    assign issue_addr_o = issue_found ? addr_q[issue_sel] : 32'h0;

    always_comb begin
        logic run;
        run        = 1'b1;
        retire_cnt = '0;
        for (int r = 0; r < RET_MAX; r++) begin
            if (run && valid_q[head_q[IW-1:0] + IW'(r)] && done_q[head_q[IW-1:0] + IW'(r)]) begin
                retire_cnt = retire_cnt + RCW'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    assign retire_cnt_o = retire_cnt;

    // Retirement is applied after the other updates; flush overrides everything.
    always_comb begin
        valid_d    = valid_q;
        addr_vld_d = addr_vld_q;
        issued_d   = issued_q;
        done_d     = done_q;
        addr_d     = addr_q;
        marker_d   = marker_q;
        head_d     = head_q;
        tail_d     = tail_q;

        if (!ldq_full_o) begin
            for (int k = 0; k < DISP_WIDTH; k++) begin
                if (disp_vld_i[k]) begin
                    valid_d[disp_slot_idx[k]]    = 1'b1;
                    addr_vld_d[disp_slot_idx[k]] = 1'b0;
                    issued_d[disp_slot_idx[k]]   = 1'b0;
                    done_d[disp_slot_idx[k]]     = 1'b0;
                    marker_d[disp_slot_idx[k]]   = disp_marker[k];
                end
            end
            tail_d = tail_q + disp_cnt;
        end

        for (int p = 0; p < EXEC_PORTS; p++) begin
            if (exec_vld_i[p] && valid_q[ex_idx[p]]) begin
                addr_d[ex_idx[p]]     = ex_addr[p];
                addr_vld_d[ex_idx[p]] = 1'b1;
            end
        end

        if (issue_found && issue_rdy_i) begin
            issued_d[issue_sel] = 1'b1;
        end

        if (resp_vld_i && valid_q[resp_idx_i] && issued_q[resp_idx_i]) begin
            done_d[resp_idx_i] = 1'b1;
        end

        for (int r = 0; r < RET_MAX; r++) begin
            if (RCW'(r) < retire_cnt) begin
                valid_d[head_q[IW-1:0] + IW'(r)]    = 1'b0;
                addr_vld_d[head_q[IW-1:0] + IW'(r)] = 1'b0;
                issued_d[head_q[IW-1:0] + IW'(r)]   = 1'b0;
                done_d[head_q[IW-1:0] + IW'(r)]     = 1'b0;
            end
        end
        head_d = head_q + PW'(retire_cnt);

        if (flush_i) begin
            valid_d    = '0;
            addr_vld_d = '0;
            issued_d   = '0;
            done_d     = '0;
            head_d     = '0;
            tail_d     = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q    <= '0;
            addr_vld_q <= '0;
            issued_q   <= '0;
            done_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            for (int i = 0; i < LDQ_ENTRIES; i++) begin
                addr_q[i]   <= '0;
                marker_q[i] <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            addr_vld_q <= addr_vld_d;
            issued_q   <= issued_d;
            done_q     <= done_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            addr_q     <= addr_d;
            marker_q   <= marker_d;
        end
    end

endmodule
